// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Purpose:
//   Read-side companion to the register-file write path. A Start pulse
//   sweeps the inclusive range FirstReg..LastReg through the register-file
//   read port. Each word goes out on a valid/ready stream, tagged with its
//   register index.
//
// Optional feature (macro DUMP_CHECKSUM_EN):
//   An XOR accumulator folds in every accepted word. One extra beat follows
//   the last register: OutData=checksum, OutIndex=0, OutLast=1.
//   Register beats then carry OutLast=0.
//
// Ports:
//   Clk           single clock, rising edge
//   Reset         synchronous, active-high reset
//   Start         dump request, sampled only while idle
//   FirstReg      first index to dump, sampled with Start
//   LastReg       last index to dump (inclusive), sampled with Start
//   ReadRegister  read address to the register file
//   ReadData      combinational read data from the register file
//   OutData       streamed word
//   OutIndex      register index of OutData
//   OutValid      OutData/OutIndex/OutLast are valid
//   OutReady      consumer accepts the beat
//   OutLast       final beat of the dump
//   Busy          dump in progress
//   Done          one-cycle pulse when the dump completes
//   Error         one-cycle pulse when Start is rejected

module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] ReadRegister,
    input  logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutIndex,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE, CSUM} state_e;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;
`endif

    // NUM_REGS is widened by one bit so that a full 2**ADDR_W table still
    // compares correctly against LastReg.
    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [ADDR_W-1:0] outIndex_q, outIndex_d;
    logic              outLast_q, outLast_d;
    logic              error_q, error_d;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    logic startBad;
    logic handshake;

    assign startBad  = (FirstReg > LastReg) || ({1'b0, LastReg} >= NumRegsW);
    assign handshake = OutValid && OutReady;

    // The read address follows idx at all times; it matters only in FETCH.
    // idx resets to 0, which gives the required reset value of ReadRegister.
    assign ReadRegister = idx_q;
    assign OutData      = outData_q;
    assign OutIndex     = outIndex_q;
    assign OutLast      = outLast_q;
    assign Error        = error_q;
    assign Busy         = (state_q != IDLE);
    assign Done         = (state_q == DONE);
`ifdef DUMP_CHECKSUM_EN
    assign OutValid     = (state_q == SEND) || (state_q == CSUM);
`else
    assign OutValid     = (state_q == SEND);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            outData_q  <= '0;
            outIndex_q <= '0;
            outLast_q  <= 1'b0;
            error_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            outData_q  <= outData_d;
            outIndex_q <= outIndex_d;
            outLast_q  <= outLast_d;
            error_q    <= error_d;
`ifdef DUMP_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        outData_d  = outData_q;
        outIndex_d = outIndex_q;
        outLast_d  = outLast_q;
        error_d    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        acc_d      = acc_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (startBad) begin
                        error_d = 1'b1;
                    end else begin
                        idx_d   = FirstReg;
                        last_d  = LastReg;
                        state_d = FETCH;
`ifdef DUMP_CHECKSUM_EN
                        acc_d   = '0;
`endif
                    end
                end
            end

            FETCH: begin
                outData_d  = ReadData;
                outIndex_d = idx_q;
`ifdef DUMP_CHECKSUM_EN
                outLast_d  = 1'b0;
`else
                outLast_d  = (idx_q == last_q);
`endif
                state_d    = SEND;
            end

            SEND: begin
                if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
                    acc_d = acc_q ^ outData_q;
`endif
                    if (idx_q == last_q) begin
`ifdef DUMP_CHECKSUM_EN
                        // The checksum beat includes the word just accepted.
                        outData_d  = acc_q ^ outData_q;
                        outIndex_d = '0;
                        outLast_d  = 1'b1;
                        state_d    = CSUM;
`else
                        state_d    = DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end

`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//
// Purpose:
//   Directed bench for regfile_dump_reader. A behavioural register-file
//   array drives ReadData combinationally from ReadRegister. Expected
//   values are hand-derived from the stream and timing rules. Outputs are
//   sampled on the falling edge.
//
// Define DUMP_CHECKSUM_EN for both files to exercise the checksum beat.

module tb_regfile_dump_reader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [4:0]  FirstReg;
    logic [4:0]  LastReg;
    logic [4:0]  ReadRegister;
    logic [31:0] ReadData;
    logic [31:0] OutData;
    logic [4:0]  OutIndex;
    logic        OutValid;
    logic        OutReady;
    logic        OutLast;
    logic        Busy;
    logic        Done;
    logic        Error;

    logic [31:0] regFile [32];

    int errors = 0;
    int checks = 0;
    int doneCount = 0;

`ifdef DUMP_CHECKSUM_EN
    localparam logic CsumEn = 1'b1;
`else
    localparam logic CsumEn = 1'b0;
`endif

    regfile_dump_reader #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .FirstReg    (FirstReg),
        .LastReg     (LastReg),
        .ReadRegister(ReadRegister),
        .ReadData    (ReadData),
        .OutData     (OutData),
        .OutIndex    (OutIndex),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutLast     (OutLast),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Combinational register-file read port.
    assign ReadData = regFile[ReadRegister];

    // Count every cycle in which Done is high.
    always @(posedge Clk) begin
        if (Done === 1'b1) doneCount <= doneCount + 1;
    end

    // Advance one cycle and land on the falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [4:0] first,
                                 input logic [4:0] last);
        Start    = start;
        FirstReg = first;
        LastReg  = last;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (OutValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(OutValid), 32'd1);
    endtask

    // Wait for a beat, check it and hold it for 'stall' cycles.
    // Then complete the handshake on the next edge.
    task automatic receiveBeat(input string tag, input logic [31:0] expData,
                               input logic [4:0] expIdx, input logic expLast,
                               input int stall);
        waitValid(tag);
        checkOutput({tag, "_data"}, OutData, expData);
        checkOutput({tag, "_idx"}, 32'(OutIndex), 32'(expIdx));
        checkOutput({tag, "_last"}, 32'(OutLast), 32'(expLast));
        for (int k = 0; k < stall; k++) begin
            OutReady = 1'b0;
            tick();
            checkOutput({tag, "_holdValid"}, 32'(OutValid), 32'd1);
            checkOutput({tag, "_holdData"}, OutData, expData);
            checkOutput({tag, "_holdIdx"}, 32'(OutIndex), 32'(expIdx));
        end
        OutReady = 1'b1;
        tick();
    endtask

    // Called right after the final register handshake. It takes the
    // checksum beat when that feature is built in, then expects Done.
    task automatic finishDump(input string tag, input logic [31:0] expCsum,
                              input int expDoneCount);
`ifdef DUMP_CHECKSUM_EN
        receiveBeat({tag, "_csum"}, expCsum, 5'd0, 1'b1, 0);
`else
        checkOutput({tag, "_csumUnused"}, expCsum, expCsum ^ 32'd0);
`endif
        checkOutput({tag, "_done"}, 32'(Done), 32'd1);
        checkOutput({tag, "_doneBusy"}, 32'(Busy), 32'd1);
        tick();
        checkOutput({tag, "_doneCleared"}, 32'(Done), 32'd0);
        checkOutput({tag, "_idleBusy"}, 32'(Busy), 32'd0);
        checkOutput({tag, "_doneCount"}, 32'(doneCount), 32'(expDoneCount));
    endtask

    initial begin
        logic [31:0] csum;
        int          doneBase;

        for (int i = 0; i < 32; i++) regFile[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
        Reset    = 1'b1;
        OutReady = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0);

        // Reset held for three cycles.
        repeat (3) tick();
        checkOutput("rst_readReg", 32'(ReadRegister), 32'd0);
        checkOutput("rst_outData", OutData, 32'd0);
        checkOutput("rst_outIndex", 32'(OutIndex), 32'd0);
        checkOutput("rst_outValid", 32'(OutValid), 32'd0);
        checkOutput("rst_outLast", 32'(OutLast), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_error", 32'(Error), 32'd0);
        Reset = 1'b0;
        tick();

        // Dump a single register.
        $display("[TB] single register dump");
        regFile[5] = 32'hDEAD_BEEF;
        OutReady = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("single_fetchBusy", 32'(Busy), 32'd1);
        checkOutput("single_fetchValid", 32'(OutValid), 32'd0);
        checkOutput("single_readReg", 32'(ReadRegister), 32'd5);
        tick();
        checkOutput("single_sendValid", 32'(OutValid), 32'd1);
        receiveBeat("single", 32'hDEAD_BEEF, 5'd5, !CsumEn, 0);
        finishDump("single", 32'hDEAD_BEEF, 1);

        // Dump range 0..3, stalling each beat for three cycles.
        $display("[TB] range with backpressure");
        regFile[0] = 32'h10;
        regFile[1] = 32'h20;
        regFile[2] = 32'h30;
        regFile[3] = 32'h40;
        OutReady = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        receiveBeat("bp0", 32'h10, 5'd0, 1'b0, 3);
        receiveBeat("bp1", 32'h20, 5'd1, 1'b0, 3);
        receiveBeat("bp2", 32'h30, 5'd2, 1'b0, 3);
        receiveBeat("bp3", 32'h40, 5'd3, !CsumEn, 3);
        finishDump("bp", 32'h40, 2);

        // An inverted range is rejected with an Error pulse.
        $display("[TB] invalid range");
        applyStimulus(1'b1, 5'd7, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("inv_error", 32'(Error), 32'd1);
        checkOutput("inv_busy", 32'(Busy), 32'd0);
        checkOutput("inv_valid", 32'(OutValid), 32'd0);
        tick();
        checkOutput("inv_errorCleared", 32'(Error), 32'd0);
        checkOutput("inv_busyAfter", 32'(Busy), 32'd0);

        // Full dump 0..31 with a Start pulse that must be ignored.
        $display("[TB] start while busy");
        for (int i = 0; i < 32; i++) regFile[i] = 32'h1234_0000 ^ (32'(i) * 32'h0101_0101);
        csum = 32'd0;
        for (int i = 0; i < 32; i++) csum = csum ^ regFile[i];
        OutReady = 1'b1;
        applyStimulus(1'b1, 5'd0, 5'd31);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        receiveBeat("full0", regFile[0], 5'd0, 1'b0, 0);
        applyStimulus(1'b1, 5'd3, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("busy_noError", 32'(Error), 32'd0);
        for (int i = 1; i < 32; i++) begin
            receiveBeat($sformatf("full%0d", i), regFile[i], 5'(i),
                        (i == 31) && !CsumEn, 0);
        end
        finishDump("full", csum, 3);
        checkOutput("full_noValid", 32'(OutValid), 32'd0);

        // Reset during the SEND of index 2 abandons the dump.
        $display("[TB] mid-dump reset");
        applyStimulus(1'b1, 5'd0, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        receiveBeat("mid0", regFile[0], 5'd0, 1'b0, 0);
        receiveBeat("mid1", regFile[1], 5'd1, 1'b0, 0);
        OutReady = 1'b0;
        waitValid("mid2");
        checkOutput("mid2_idx", 32'(OutIndex), 32'd2);
        doneBase = doneCount;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("midRst_valid", 32'(OutValid), 32'd0);
        checkOutput("midRst_busy", 32'(Busy), 32'd0);
        checkOutput("midRst_done", 32'(Done), 32'd0);
        checkOutput("midRst_data", OutData, 32'd0);
        tick();
        checkOutput("midRst_stillIdle", 32'(Busy), 32'd0);
        checkOutput("midRst_noDone", 32'(doneCount), 32'(doneBase));
        OutReady = 1'b1;
        applyStimulus(1'b1, 5'd1, 5'd2);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0);
        receiveBeat("restart1", regFile[1], 5'd1, 1'b0, 0);
        receiveBeat("restart2", regFile[2], 5'd2, !CsumEn, 0);
        finishDump("restart", regFile[1] ^ regFile[2], doneBase + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
